// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin, burst-locked merge of NUM_REQ byte streams onto one
// registered AXI-stream byte link toward a UART transmitter. Rev 1.0
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   s_tvalid,
  output logic [NUM_REQ-1:0]   s_tready,
  input  logic [8*NUM_REQ-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]   s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tlast,
  output logic [ID_W-1:0]      m_tid,
  output logic                 busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int IC_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [IC_W-1:0] IDLE_MAX   = IC_W'(IDLE_TIMEOUT);
  localparam logic [IC_W-1:0] IDLE_LAST  = IC_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   g, g_nxt, ptr, ptr_nxt, pick_idx;
  logic              pick_found;
  logic [NUM_REQ-1:0] rot_valid;
  logic [BC_W-1:0]   burst_cnt;
  logic [IC_W-1:0]   idle_cnt;
  logic              sel_valid, sel_last;
  logic [7:0]        sel_data;
  logic              own_ready, xfer, grant_now, release_now, timeout;

  // rot_valid[k] is the request of source (ptr+k) mod NUM_REQ; lowest k wins.
  always_comb begin
    int unsigned idx;
    rot_valid  = NUM_REQ'({s_tvalid, s_tvalid} >> ptr);
    pick_found = 1'b0;
    pick_idx   = ptr;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        idx        = (int'(ptr) + k) % NUM_REQ;
        pick_found = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == ID_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    g_nxt       = g;
    ptr_nxt     = ptr;
    s_tready    = '0;
    own_ready   = 1'b0;
    xfer        = 1'b0;
    grant_now   = 1'b0;
    release_now = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = LOCKED;
          g_nxt     = pick_idx;
          grant_now = 1'b1;
        end
      end
      LOCKED: begin
        own_ready = !m_tvalid || m_tready;
        for (int i = 0; i < NUM_REQ; i++) begin
          s_tready[i] = own_ready && (g == ID_W'(i));
        end
        xfer        = sel_valid && own_ready;
        timeout     = (IDLE_TIMEOUT > 0) && !sel_valid && (idle_cnt == IDLE_LAST);
        // tlast and the burst cap on the same byte still give a single release
        release_now = (xfer && (sel_last || (burst_cnt == BURST_LAST))) || timeout;
        if (release_now) begin
          state_nxt = IDLE;
          ptr_nxt   = (g == LAST_ID) ? '0 : g + ID_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (grant_now) begin
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == LOCKED) begin
      if (xfer) begin
        burst_cnt <= burst_cnt + BC_W'(1);
      end
      if (sel_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= 8'h00;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (xfer) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_tlast  <= sel_last;
      m_tid    <= g;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  assign busy = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
// with NUM_REQ=4, MAX_BURST=4, IDLE_TIMEOUT=8. Rev 1.0
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   s_tvalid, s_tready, s_tlast;
  logic [8*NR-1:0] s_tdata;
  logic            m_tvalid, m_tready, m_tlast, busy;
  logic [7:0]      m_tdata;
  logic [1:0]      m_tid;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tid(m_tid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-source byte FIFOs: {tlast, data}
  logic [8:0] mem [NR][16];
  int head [NR];
  int tail [NR];

  // Every accepted output byte as {tid, tlast, data} with its cycle number
  logic [10:0] cap_word [128];
  int          cap_cyc  [128];
  int          n_cap = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1 && n_cap < 128) begin
      cap_word[n_cap] = {m_tid, m_tlast, m_tdata};
      cap_cyc[n_cap]  = cyc;
      n_cap           = n_cap + 1;
    end
  end

  task automatic push(input int src, input logic [7:0] d, input logic l);
    mem[src][tail[src]] = {l, d};
    tail[src] = tail[src] + 1;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (head[i] != tail[i]) begin
        s_tvalid[i]       = 1'b1;
        s_tlast[i]        = mem[i][head[i]][8];
        s_tdata[8*i +: 8] = mem[i][head[i]][7:0];
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tlast[i]        = 1'b0;
        s_tdata[8*i +: 8] = 8'h00;
      end
    end
  endtask

  // Advance one cycle: handshakes are sampled mid-cycle, sources update after the edge.
  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) head[i] = head[i] + 1;
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 8'h00) begin n_bad++; $display("FAIL reset_m_tdata: got %h want 00", m_tdata); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_m_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (m_tid !== 2'd0) begin n_bad++; $display("FAIL reset_m_tid: got %0d want 0", m_tid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL reset_s_tready: got %b want 0000", s_tready); end
  endtask

  task automatic test_single_source();
    int n0, t0;
    logic [10:0] ew [3];
    do_reset();
    n0 = n_cap;
    t0 = cyc;
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    drive();
    #1;
    n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL single_idle_ready: got %b want 0000", s_tready); end
    step(); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_grant: got %b want 1", busy); end
    n_cmp++; if (s_tready !== 4'b0010) begin n_bad++; $display("FAIL single_ready_grant: got %b want 0010", s_tready); end
    step(); #1;
    n_cmp++;
    if ({m_tvalid, m_tid, m_tlast, m_tdata} !== {1'b1, 2'd1, 1'b0, 8'h41}) begin
      n_bad++; $display("FAIL single_first_out: got v%b id%0d l%b %h want v1 id1 l0 41", m_tvalid, m_tid, m_tlast, m_tdata);
    end
    step(); step(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_release: got %b want 0", busy); end
    repeat (3) step();
    ew[0] = {2'd1, 1'b0, 8'h41}; ew[1] = {2'd1, 1'b0, 8'h42}; ew[2] = {2'd1, 1'b1, 8'h43};
    n_cmp++; if (n_cap - n0 !== 3) begin n_bad++; $display("FAIL single_count: got %0d want 3", n_cap - n0); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (cap_word[n0+k] !== ew[k] || cap_cyc[n0+k] !== t0 + 2 + k) begin
        n_bad++; $display("FAIL single_byte%0d: got %h@%0d want %h@%0d", k, cap_word[n0+k], cap_cyc[n0+k], ew[k], t0 + 2 + k);
      end
    end
  endtask

  task automatic test_contention();
    int n0, t0;
    logic [10:0] ew [4];
    int ec [4];
    do_reset();
    n0 = n_cap;
    t0 = cyc;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    drive();
    repeat (8) step();
    ew[0] = {2'd0, 1'b0, 8'hA0}; ec[0] = t0 + 2;
    ew[1] = {2'd0, 1'b1, 8'hA1}; ec[1] = t0 + 3;
    ew[2] = {2'd2, 1'b0, 8'hC0}; ec[2] = t0 + 5;
    ew[3] = {2'd2, 1'b1, 8'hC1}; ec[3] = t0 + 6;
    n_cmp++; if (n_cap - n0 !== 4) begin n_bad++; $display("FAIL contention_count: got %0d want 4", n_cap - n0); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (cap_word[n0+k] !== ew[k] || cap_cyc[n0+k] !== ec[k]) begin
        n_bad++; $display("FAIL contention_byte%0d: got %h@%0d want %h@%0d", k, cap_word[n0+k], cap_cyc[n0+k], ew[k], ec[k]);
      end
    end
    // Pointer now sits at 3, so source 3 beats source 0 on a tie.
    n0 = n_cap;
    push(0, 8'h10, 1'b1); push(3, 8'h30, 1'b1);
    drive();
    repeat (6) step();
    ew[0] = {2'd3, 1'b1, 8'h30};
    ew[1] = {2'd0, 1'b1, 8'h10};
    n_cmp++; if (n_cap - n0 !== 2) begin n_bad++; $display("FAIL ptr_count: got %0d want 2", n_cap - n0); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (cap_word[n0+k] !== ew[k]) begin
        n_bad++; $display("FAIL ptr_order%0d: got %h want %h", k, cap_word[n0+k], ew[k]);
      end
    end
  endtask

  task automatic test_burst_cap();
    int n0, t0;
    logic [10:0] ew [8];
    int ec [8];
    do_reset();
    n0 = n_cap;
    t0 = cyc;
    for (int k = 0; k < 6; k++) push(3, 8'(8'h60 + k), 1'b0);
    drive();
    step();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
    drive();
    repeat (14) step();
    for (int k = 0; k < 4; k++) begin
      ew[k] = {2'd3, 1'b0, 8'(8'h60 + k)};
      ec[k] = t0 + 2 + k;
    end
    ew[4] = {2'd0, 1'b0, 8'h01}; ec[4] = t0 + 7;
    ew[5] = {2'd0, 1'b1, 8'h02}; ec[5] = t0 + 8;
    ew[6] = {2'd3, 1'b0, 8'h64}; ec[6] = t0 + 10;
    ew[7] = {2'd3, 1'b0, 8'h65}; ec[7] = t0 + 11;
    n_cmp++; if (n_cap - n0 !== 8) begin n_bad++; $display("FAIL burst_count: got %0d want 8", n_cap - n0); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (cap_word[n0+k] !== ew[k] || cap_cyc[n0+k] !== ec[k]) begin
        n_bad++; $display("FAIL burst_byte%0d: got %h@%0d want %h@%0d", k, cap_word[n0+k], cap_cyc[n0+k], ew[k], ec[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    logic [10:0] ew [5];
    do_reset();
    n0 = n_cap;
    for (int k = 0; k < 5; k++) push(0, 8'(8'hB0 + k), (k == 4));
    drive();
    step(); step(); step();
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) step();
      #1;
      n_cmp++;
      if ({m_tvalid, m_tlast, m_tdata, s_tready} !== {1'b1, 1'b0, 8'hB1, 4'b0000}) begin
        n_bad++; $display("FAIL bp_hold%0d: got v%b l%b %h rdy%b want v1 l0 b1 rdy0000", k, m_tvalid, m_tlast, m_tdata, s_tready);
      end
    end
    m_tready = 1'b1;
    repeat (8) step();
    for (int k = 0; k < 5; k++) ew[k] = {2'd0, (k == 4), 8'(8'hB0 + k)};
    n_cmp++; if (n_cap - n0 !== 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", n_cap - n0); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (cap_word[n0+k] !== ew[k]) begin
        n_bad++; $display("FAIL bp_byte%0d: got %h want %h", k, cap_word[n0+k], ew[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int n0, t0;
    do_reset();
    n0 = n_cap;
    t0 = cyc;
    push(2, 8'h22, 1'b0);
    drive();
    step();
    push(1, 8'h11, 1'b1);
    drive();
    repeat (8) step();
    #1;
    n_cmp++;
    if (busy !== 1'b1 || s_tready !== 4'b0100) begin
      n_bad++; $display("FAIL timeout_last_idle: got busy%b rdy%b want busy1 rdy0100", busy, s_tready);
    end
    step(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_release: got %b want 0", busy); end
    step(); #1;
    n_cmp++;
    if (busy !== 1'b1 || s_tready !== 4'b0010) begin
      n_bad++; $display("FAIL timeout_regrant: got busy%b rdy%b want busy1 rdy0010", busy, s_tready);
    end
    repeat (3) step();
    n_cmp++; if (n_cap - n0 !== 2) begin n_bad++; $display("FAIL timeout_count: got %0d want 2", n_cap - n0); end
    n_cmp++;
    if (cap_word[n0] !== {2'd2, 1'b0, 8'h22} || cap_cyc[n0] !== t0 + 2) begin
      n_bad++; $display("FAIL timeout_byte0: got %h@%0d want 222@%0d", cap_word[n0], cap_cyc[n0], t0 + 2);
    end
    n_cmp++;
    if (cap_word[n0+1] !== {2'd1, 1'b1, 8'h11} || cap_cyc[n0+1] !== t0 + 12) begin
      n_bad++; $display("FAIL timeout_byte1: got %h@%0d want 311@%0d", cap_word[n0+1], cap_cyc[n0+1], t0 + 12);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n0;
    do_reset();
    push(2, 8'h5A, 1'b0); push(2, 8'h5B, 1'b0); push(2, 8'h5C, 1'b1);
    drive();
    step();
    m_tready = 1'b0;
    step(); #1;
    n_cmp++;
    if ({m_tvalid, m_tid, m_tdata} !== {1'b1, 2'd2, 8'h5A}) begin
      n_bad++; $display("FAIL rstmid_pre: got v%b id%0d %h want v1 id2 5a", m_tvalid, m_tid, m_tdata);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_tvalid, m_tlast, m_tdata, m_tid, busy, s_tready} !== {1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL rstmid_outputs: got v%b l%b %h id%0d busy%b rdy%b want all zero", m_tvalid, m_tlast, m_tdata, m_tid, busy, s_tready);
    end
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    n0 = n_cap;
    repeat (3) step();
    n_cmp++; if (n_cap - n0 !== 0) begin n_bad++; $display("FAIL rstmid_discard: got %0d bytes want 0", n_cap - n0); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_burst_cap();
    test_backpressure();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
